// File: rtl/cmd_frame_pkg.sv
// Shared constants for the command frame sender: packet headers, command
// encodings, per-command byte counts, FSM state encoding and prescale floor.
package cmd_frame_pkg;

    localparam logic [7:0] HDR_REG_WRITE = 8'hAA;
    localparam logic [7:0] HDR_REG_READ  = 8'hBB;
    localparam logic [7:0] HDR_ALU_OP    = 8'hCC;
    localparam logic [7:0] HDR_ALU_NOP   = 8'hDD;

    typedef enum logic [1:0] {
        CMD_REG_WRITE = 2'd0,
        CMD_REG_READ  = 2'd1,
        CMD_ALU_OP    = 2'd2,
        CMD_ALU_NOP   = 2'd3
    } cmd_type_e;

    localparam int LEN_REG_WRITE = 3;
    localparam int LEN_REG_READ  = 2;
    localparam int LEN_ALU_OP    = 4;
    localparam int LEN_ALU_NOP   = 2;

    localparam logic [5:0] MIN_PRESCALE = 6'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_e;

    function automatic logic [7:0] header_of(input cmd_type_e t);
        case (t)
            CMD_REG_WRITE: return HDR_REG_WRITE;
            CMD_REG_READ:  return HDR_REG_READ;
            CMD_ALU_OP:    return HDR_ALU_OP;
            default:       return HDR_ALU_NOP;
        endcase
    endfunction

    // Index of the final packet byte; the byte counter compares against this.
    function automatic logic [1:0] last_index_of(input cmd_type_e t);
        case (t)
            CMD_REG_WRITE: return 2'(LEN_REG_WRITE - 1);
            CMD_REG_READ:  return 2'(LEN_REG_READ - 1);
            CMD_ALU_OP:    return 2'(LEN_ALU_OP - 1);
            default:       return 2'(LEN_ALU_NOP - 1);
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit tick generator: tick marks the last cycle of a bit period of
// `prescale` cycles, pre_tick the cycle before it.
module uart_bit_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] prescale,
    output logic       tick,
    output logic       pre_tick
);

    logic [5:0] cnt;

    assign tick     = en && (cnt == prescale - 6'd1);
    assign pre_tick = en && (cnt == prescale - 6'd2);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 6'd1;
        end
    end

endmodule

// File: rtl/cmd_frame_sender.sv
// Serialises a command into 2-4 UART byte frames on TX_OUT.
// Define CMD_FRAME_PARITY_EN to add a parity bit to every frame.
module cmd_frame_sender
    import cmd_frame_pkg::*;
#(
    parameter int Data_width = 8,
    parameter int Gap_bits   = 2
) (
    input  logic                  UART_clk,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_type,
    input  logic [Data_width-1:0] cmd_arg0,
    input  logic [Data_width-1:0] cmd_arg1,
    input  logic [Data_width-1:0] cmd_arg2,
    input  logic [5:0]            Prescale,
    input  logic                  Parity_type,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  pkt_done
);

    // Gap_bits must be at least 1: the FSM always passes through GAP.
    localparam int BW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam int GW = (Gap_bits > 1) ? $clog2(Gap_bits) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(Data_width - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(Gap_bits - 1);

    state_e                state;
    logic [BW-1:0]         bit_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [1:0]            byte_cnt;
    logic [1:0]            last_byte;
    logic [5:0]            presc_q;
    logic [Data_width-1:0] byte_q [4];
    logic [Data_width-1:0] shift_q;
    logic                  tick;
    logic                  pre_tick;
    logic                  accept;
    logic                  gap_last;
    logic                  byte_last;

    assign cmd_ready = !busy;
    assign accept    = cmd_valid && cmd_ready;
    assign gap_last  = (gap_cnt == GAP_LAST);
    assign byte_last = (byte_cnt == last_byte);

`ifdef CMD_FRAME_PARITY_EN
    logic par_type_q;
    logic parity_bit;
    assign parity_bit = (^byte_q[byte_cnt]) ^ par_type_q;

    always_ff @(posedge UART_clk) begin
        if (accept) par_type_q <= Parity_type;
    end
`else
    logic unused_parity_type;
    assign unused_parity_type = Parity_type;
`endif

    uart_bit_timer u_bit_timer (
        .clk      (UART_clk),
        .rst      (RST),
        .en       (busy),
        .prescale (presc_q),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    // NOTE: payload storage is only read while busy, so it carries no reset;
    // that keeps the byte array free of reset muxing.
    always_ff @(posedge UART_clk) begin
        if (accept) begin
            byte_q[0] <= Data_width'(header_of(cmd_type_e'(cmd_type)));
            byte_q[1] <= cmd_arg0;
            byte_q[2] <= cmd_arg1;
            byte_q[3] <= cmd_arg2;
            presc_q   <= (Prescale < MIN_PRESCALE) ? MIN_PRESCALE : Prescale;
            last_byte <= last_index_of(cmd_type_e'(cmd_type));
        end
        if (tick && state == START) begin
            shift_q <= byte_q[byte_cnt] >> 1;
        end else if (tick && state == DATA) begin
            shift_q <= shift_q >> 1;
        end
    end

    // Each state drives its own bit level; transitions happen on the tick
    // closing the current bit, so every bit lasts exactly presc_q cycles.
    always_ff @(posedge UART_clk) begin
        if (RST) begin
            state    <= IDLE;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            // Registered one cycle early so the pulse lands on the last gap cycle.
            pkt_done <= (state == GAP) && gap_last && byte_last && pre_tick;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= START;
                        TX_OUT   <= 1'b0;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        TX_OUT  <= byte_q[byte_cnt][0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef CMD_FRAME_PARITY_EN
                            state   <= PARITY;
                            TX_OUT  <= parity_bit;
`else
                            state   <= STOP;
                            TX_OUT  <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            TX_OUT  <= shift_q[0];
                        end
                    end
                end
`ifdef CMD_FRAME_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        state   <= GAP;
                        TX_OUT  <= 1'b1;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_last) begin
                            gap_cnt <= '0;
                            if (byte_last) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                byte_cnt <= '0;
                            end else begin
                                state    <= START;
                                TX_OUT   <= 1'b0;
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_sender.sv
// Directed bench for cmd_frame_sender: checks TX_OUT/busy/cmd_ready/pkt_done
// every cycle of each packet against a bit-stream built from the packet bytes.
module tb_cmd_frame_sender;

    localparam int DW  = 8;
    localparam int GAP = 2;
`ifdef CMD_FRAME_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FB = DW + 2 + P + GAP;  // bits per byte frame

    logic       UART_clk = 1'b0;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic [7:0] cmd_arg2;
    logic [5:0] Prescale;
    logic       Parity_type;
    logic       TX_OUT;
    logic       busy;
    logic       pkt_done;

    int vectors     = 0;
    int miscompares = 0;
    logic exp_bits[$];

    always #5 UART_clk = ~UART_clk;

    cmd_frame_sender #(.Data_width(DW), .Gap_bits(GAP)) dut (
        .UART_clk    (UART_clk),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_arg0    (cmd_arg0),
        .cmd_arg1    (cmd_arg1),
        .cmd_arg2    (cmd_arg2),
        .Prescale    (Prescale),
        .Parity_type (Parity_type),
        .TX_OUT      (TX_OUT),
        .busy        (busy),
        .pkt_done    (pkt_done)
    );

    // Observed vector: {TX_OUT, busy, cmd_ready, pkt_done}
    function automatic logic [3:0] outs();
        return {TX_OUT, busy, cmd_ready, pkt_done};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Serial line contents for one packet, one entry per bit period.
    task automatic build_stream(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input logic pt);
        logic [7:0] pkt [4];
        int n;
        pkt[1] = a0;
        pkt[2] = a1;
        pkt[3] = a2;
        case (t)
            2'd0:    begin pkt[0] = 8'hAA; n = 3; end
            2'd1:    begin pkt[0] = 8'hBB; n = 2; end
            2'd2:    begin pkt[0] = 8'hCC; n = 4; end
            default: begin pkt[0] = 8'hDD; n = 2; end
        endcase
        exp_bits.delete();
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(1'b0);
            for (int b = 0; b < DW; b++) exp_bits.push_back(pkt[i][b]);
            if (P == 1) exp_bits.push_back((^pkt[i]) ^ pt);
            exp_bits.push_back(1'b1);
            for (int g = 0; g < GAP; g++) exp_bits.push_back(1'b1);
        end
    endtask

    task automatic run_packet(input string name, input logic [1:0] t, input logic [7:0] a0,
                              input logic [7:0] a1, input logic [7:0] a2, input logic [5:0] presc,
                              input logic pt, input int exp_len, input bit hold_valid,
                              input int abort_at);
        int pe;
        pe = (presc < 6'd4) ? 4 : int'(presc);
        build_stream(t, a0, a1, a2, pt);
        @(posedge UART_clk); #1;
        cmd_type    = t;
        cmd_arg0    = a0;
        cmd_arg1    = a1;
        cmd_arg2    = a2;
        Prescale    = presc;
        Parity_type = pt;
        cmd_valid   = 1'b1;
        @(posedge UART_clk); #1;
        // Scramble inputs after accept; the packet must not change.
        cmd_valid   = hold_valid;
        cmd_type    = ~t;
        cmd_arg0    = ~a0;
        cmd_arg1    = ~a1;
        cmd_arg2    = ~a2;
        Prescale    = 6'd63;
        Parity_type = ~pt;
        for (int i = 1; i <= exp_len; i++) begin
            @(negedge UART_clk);
            check($sformatf("%s cycle %0d", name, i), outs(),
                  {exp_bits[(i - 1) / pe], 1'b1, 1'b0, 1'(i == exp_len)});
            if (i == abort_at) break;
        end
        if (abort_at > 0) begin
            RST = 1'b1;
            @(negedge UART_clk);
            check({name, " reset abort"}, outs(), 4'b1010);
            RST = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge UART_clk);
                check($sformatf("%s post-abort idle %0d", name, i), outs(), 4'b1010);
            end
        end else begin
            @(negedge UART_clk);
            check({name, " ready after done"}, outs(), 4'b1010);
            cmd_valid = 1'b0;
            @(negedge UART_clk);
            check({name, " stays idle"}, outs(), 4'b1010);
        end
    endtask

    initial begin
        RST         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_type    = 2'd0;
        cmd_arg0    = 8'h00;
        cmd_arg1    = 8'h00;
        cmd_arg2    = 8'h00;
        Prescale    = 6'd8;
        Parity_type = 1'b0;
        repeat (2) @(posedge UART_clk);
        @(negedge UART_clk);
        check("reset state", outs(), 4'b1010);
        RST = 1'b0;
        @(negedge UART_clk);
        check("idle after reset", outs(), 4'b1010);

        // Register write: AA 05 55, 8 cycles per bit, even parity.
        run_packet("write", 2'd0, 8'h05, 8'h55, 8'h00, 6'd8, 1'b0, 3 * FB * 8, 1'b0, 0);
        // ALU with operands: CC 0A 19 00, 16 cycles per bit (832 cycles with parity).
        run_packet("alu", 2'd2, 8'h0A, 8'h19, 8'h00, 6'd16, 1'b0, 4 * FB * 16, 1'b0, 0);
        // Register read, odd parity, cmd_valid held high through pkt_done.
        run_packet("read", 2'd1, 8'h05, 8'h00, 8'h00, 6'd5, 1'b1, 2 * FB * 5, 1'b1, 0);
        // Prescale below the floor is clamped to 4.
        run_packet("presc2", 2'd0, 8'h3C, 8'hC3, 8'h00, 6'd2, 1'b0, 3 * FB * 4, 1'b0, 0);
        // Reset in the data bits of the second byte (DD 07).
        run_packet("abort", 2'd3, 8'h07, 8'h00, 8'h00, 6'd4, 1'b0, 2 * FB * 4, 1'b0, FB * 4 + 10);
        // Clean accept after the abort: DD 0A.
        run_packet("recover", 2'd3, 8'h0A, 8'h00, 8'h00, 6'd4, 1'b1, 2 * FB * 4, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cmd_frame_sender.md
CMD_FRAME_SENDER -- requirements
Module: cmd_frame_sender

Interface
REQ-001 Parameter Data_width, default 8, byte width of every UART data field.
REQ-002 Parameter Gap_bits, default 2, number of idle (high) bit periods inserted after each stop bit.
REQ-003 UART_clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high when a command can be accepted.
REQ-007 cmd_type  input  2  command type: 0 = reg write, 1 = reg read, 2 = ALU with operands, 3 = ALU no operands.
REQ-008 cmd_arg0, cmd_arg1, cmd_arg2  input  Data_width each  command payload bytes.
REQ-009 Prescale  input  6  UART_clk cycles per bit; sampled at command accept.
REQ-010 Parity_type  input  1  parity sense: 0 = even, 1 = odd; sampled at accept.
REQ-011 TX_OUT  output  1  serial line to the system RX_IN; idles high.
REQ-012 busy  output  1  high from accept until the final gap period ends.
REQ-013 pkt_done  output  1  single-cycle pulse on the last cycle of the final gap.

Function
REQ-014 Accept occurs on a cycle with cmd_valid && cmd_ready; cmd_ready = !busy.
REQ-015 The block SHALL register cmd_type, all args, Prescale and Parity_type at accept; input changes during busy have no effect.
REQ-016 Packet bytes SHALL be: type 0 = AA, arg0 (addr), arg1 (data); type 1 = BB, arg0; type 2 = CC, arg0 (A), arg1 (B), arg2 (op); type 3 = DD, arg0 (op).
REQ-017 Each byte frame SHALL be: start (0), Data_width data bits LSB first, optional parity bit, stop (1), then Gap_bits idle high bits.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP, GAP; IDLE->START on accept; START->DATA; DATA->PARITY (parity compiled in) or STOP after bit Data_width-1; PARITY->STOP; STOP->GAP; GAP->START if bytes remain, else IDLE.
REQ-019 TX_OUT SHALL go low on the first cycle after accept (1-cycle latency).
REQ-020 Every bit, including gap bits, SHALL be held exactly Prescale_eff cycles, where Prescale_eff = max(Prescale, 4).
REQ-021 A bit counter SHALL index data bits 0..Data_width-1; a byte counter SHALL index packet bytes 0..len-1, with len in 2..4 from REQ-016.
REQ-022 Parity SHALL be the XOR of the data bits, inverted when the latched Parity_type = 1.
REQ-023 Total packet duration SHALL be len * (Data_width + 2 + P + Gap_bits) * Prescale_eff cycles, where P = 1 with parity and 0 without.
REQ-024 cmd_valid asserted in the same cycle pkt_done pulses SHALL NOT be accepted; cmd_ready rises the following cycle.
REQ-025 TX_OUT SHALL be registered and glitch-free.

Reset
REQ-026 On RST = 1 at a clock edge: state = IDLE, TX_OUT = 1, busy = 0, cmd_ready = 1 on the following cycle, pkt_done = 0, and all counters = 0.
REQ-027 RST mid-packet SHALL abort the packet immediately; TX_OUT returns high on the next edge and no pkt_done is produced.

Configuration
REQ-028 Macro CMD_FRAME_PARITY_EN: when defined, the PARITY state and parity bit are present (P = 1); when undefined, the PARITY state is absent, Parity_type is ignored and P = 0.

Structure
REQ-029 Package cmd_frame_pkg SHALL hold: the header constants AA/BB/CC/DD, the cmd_type encodings, the per-type byte counts, the FSM state encoding and the minimum prescale (4).
REQ-030 One sub-module, uart_bit_timer, SHALL generate the per-bit tick from Prescale_eff; the FSM and byte sequencing stay in cmd_frame_sender.

Verification
REQ-031 Write: type 0, arg0 = 05, arg1 = 55, Prescale = 8, even parity -> bytes AA, 05, 55 on TX_OUT with parity bits 0, 0, 0, each bit 8 cycles; one pkt_done.
REQ-032 ALU: type 2, args 0A, 19, 00, Prescale = 16 -> bytes CC, 0A, 19, 00; with parity compiled in, duration 4*13*16 = 832 cycles.
REQ-033 Read: type 1, arg0 = 05, odd parity -> bytes BB, 05 with parity bits 1, 1; cmd_ready low throughout and high the cycle after pkt_done.
REQ-034 Prescale = 2 -> every bit held 4 cycles.
REQ-035 RST asserted during the second byte of type 3 (DD, 07) -> TX_OUT = 1 on the next edge, no pkt_done, and a new command is accepted cleanly.
REQ-036 Build without CMD_FRAME_PARITY_EN: type 3, arg0 = 0A -> frames of 10 bits plus gap, no parity bit.
